// File: rtl/request_pending_latch_pkg.sv
// Shared widths and FSM state encodings for request_pending_latch and its
// edge-detect front end.
package request_pending_latch_pkg;

  localparam int N     = 4;
  localparam int CW    = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/req_edge_detect.sv
// Rising-edge detector for the raw request vector. With REQ_SYNC_EN defined the
// requests first pass through a 2-flop synchronizer; otherwise they are used directly.
module req_edge_detect
  import request_pending_latch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] rise
);

  logic [N-1:0] req_s;
  logic [N-1:0] req_prev;

`ifdef REQ_SYNC_EN
  logic [N-1:0] sync_q1;
  logic [N-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req_in;
      sync_q2 <= sync_q1;
    end
  end

  assign req_s = sync_q2;
`else
  assign req_s = req_in;
`endif

  // Resetting to 0 makes a line held high through reset count as one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_prev <= '0;
    else     req_prev <= req_s;
  end

  assign rise = req_s & ~req_prev;

endmodule

// File: rtl/request_pending_latch.sv
// Sticky pending latch feeding an external priority encoder, with a valid/ready
// offer FSM and a saturating lost-event counter. Optional macro: REQ_SYNC_EN.
module request_pending_latch
  import request_pending_latch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pend_out,
  input  logic             enc_valid,
  input  logic [CW-1:0]    enc_code,
  output logic             svc_valid,
  output logic [CW-1:0]    svc_code,
  input  logic             svc_ready,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam logic [CNT_W-1:0] LOST_MAX = '1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] svc_code_next;
  logic [N-1:0]  rise;
  logic [N-1:0]  clr_vec;
  logic          handshake;
  logic          lost_event;

  req_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .rise   (rise)
  );

  assign svc_valid = (state == ST_OFFER);
  assign handshake = svc_valid & svc_ready;
  assign pend_out  = pending & mask;

  always_comb begin
    clr_vec = '0;
    if (handshake) clr_vec[svc_code] = 1'b1;
  end

  // An edge on a bit being cleared this cycle re-arms it rather than being lost.
  assign lost_event = |(rise & pending & ~clr_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      lost_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
      if (lost_event && (lost_cnt != LOST_MAX)) lost_cnt <= lost_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      svc_code <= '0;
    end else begin
      state    <= state_next;
      svc_code <= svc_code_next;
    end
  end

  // GAP gives pend_out and the encoder one cycle to settle after a clear.
  always_comb begin
    state_next    = state;
    svc_code_next = svc_code;
    case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          svc_code_next = enc_code;
          state_next    = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (svc_ready) state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_request_pending_latch.sv
// Self-checking bench for request_pending_latch: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_request_pending_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic [3:0] mask = 4'hF;
  logic [3:0] pend_out;
  logic       enc_valid;
  logic [1:0] enc_code;
  logic       svc_valid;
  logic [1:0] svc_code;
  logic       svc_ready = 1'b0;
  logic [3:0] pending;
  logic [7:0] lost_cnt;

  int total = 0;
  int bad = 0;

  request_pending_latch dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .pend_out  (pend_out),
    .enc_valid (enc_valid),
    .enc_code  (enc_code),
    .svc_valid (svc_valid),
    .svc_code  (svc_code),
    .svc_ready (svc_ready),
    .pending   (pending),
    .lost_cnt  (lost_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the 4-to-2 priority encoder: highest set bit wins.
  always_comb begin
    enc_valid = |pend_out;
    enc_code  = 2'd0;
    for (int i = 0; i < 4; i++) if (pend_out[i]) enc_code = 2'(i);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, lost count, and the offer timeline.
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  int         m_lost;
  bit         m_valid;
  int         m_code;
  longint     edge_no = 0;
  longint     m_earliest;

  always @(posedge clk or posedge rst) begin
    logic [3:0] req_s;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] vis;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_lost = 0; m_valid = 0; m_code = 0; m_earliest = 0;
    end else begin
      edge_no++;
`ifdef REQ_SYNC_EN
      req_s = m_s2;
      m_s2  = m_s1;
      m_s1  = req_in;
`else
      req_s = req_in;
`endif
      rise   = req_s & ~m_prev;
      m_prev = req_s;
      clr    = '0;
      vis    = m_pend & mask;
      if (m_valid) begin
        if (svc_ready) begin
          clr[m_code] = 1'b1;
          m_valid     = 0;
          m_earliest  = edge_no + 2;
        end
      end else if (edge_no >= m_earliest && vis != 0) begin
        for (int i = 0; i < 4; i++) if (vis[i]) m_code = i;
        m_valid = 1;
      end
      if (((rise & m_pend & ~clr) != 0) && m_lost < 255) m_lost++;
      m_pend = (m_pend & ~clr) | rise;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("pending", 32'(pending), 32'(m_pend));
    checkOutput("pend_out", 32'(pend_out), 32'(m_pend & mask));
    checkOutput("svc_valid", 32'(svc_valid), 32'(m_valid));
    if (m_valid) checkOutput("svc_code", 32'(svc_code), 32'(m_code));
    checkOutput("lost_cnt", 32'(lost_cnt), 32'(m_lost));
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m, input logic rdy);
    req_in    = r;
    mask      = m;
    svc_ready = rdy;
  endtask

  task automatic doReset();
    applyStimulus(4'h0, 4'hF, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int codes[$];
    int when[$];
    tick(2);
    checkOutput("reset svc_valid", 32'(svc_valid), 32'd0);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset lost_cnt", 32'(lost_cnt), 32'd0);
    rst = 1'b0;
    tick(1);

    // Single pulse on bit 0, offered two cycles after the edge, then accepted.
    applyStimulus(4'b0001, 4'hF, 1'b0); tick();
    checkOutput("t1 pending set", 32'(pending), 32'h1);
    checkOutput("t1 not yet offered", 32'(svc_valid), 32'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0); tick();
    checkOutput("t1 offer valid", 32'(svc_valid), 32'd1);
    checkOutput("t1 offer code", 32'(svc_code), 32'd0);
    applyStimulus(4'b0000, 4'hF, 1'b1); tick();
    checkOutput("t1 cleared", 32'(pending), 32'h0);
    checkOutput("t1 valid dropped", 32'(svc_valid), 32'd0);

    // Three simultaneous edges drained in priority order, one per 3 cycles.
    applyStimulus(4'b1011, 4'hF, 1'b1); tick();
    applyStimulus(4'b0000, 4'hF, 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (svc_valid) begin
        codes.push_back(int'(svc_code));
        when.push_back(c);
      end
    end
    checkOutput("t2 offer count", 32'(codes.size()), 32'd3);
    if (codes.size() == 3) begin
      checkOutput("t2 first code", 32'(codes[0]), 32'd3);
      checkOutput("t2 second code", 32'(codes[1]), 32'd1);
      checkOutput("t2 third code", 32'(codes[2]), 32'd0);
      checkOutput("t2 spacing a", 32'(when[1] - when[0]), 32'd3);
      checkOutput("t2 spacing b", 32'(when[2] - when[1]), 32'd3);
    end
    checkOutput("t2 drained", 32'(pending), 32'h0);

    // Masked bit 3 stays pending and is offered only once unmasked.
    applyStimulus(4'b1000, 4'b0111, 1'b0); tick();
    applyStimulus(4'b0000, 4'b0111, 1'b0); tick(4);
    checkOutput("t3 masked no offer", 32'(svc_valid), 32'd0);
    checkOutput("t3 masked pending", 32'(pending), 32'h8);
    applyStimulus(4'b0000, 4'hF, 1'b0); tick();
    checkOutput("t3 unmasked offer", 32'(svc_valid), 32'd1);
    checkOutput("t3 unmasked code", 32'(svc_code), 32'd3);
    checkOutput("t3 held pending", 32'(pending), 32'h8);
    applyStimulus(4'b0000, 4'hF, 1'b1); tick();
    checkOutput("t3 accepted", 32'(pending), 32'h0);

    // Lost event, then edge coinciding with its own accept.
    doReset();
    applyStimulus(4'b0100, 4'hF, 1'b0); tick();
    applyStimulus(4'b0000, 4'hF, 1'b0); tick();
    applyStimulus(4'b0100, 4'hF, 1'b0); tick();
    checkOutput("t4 lost one", 32'(lost_cnt), 32'd1);
    applyStimulus(4'b0000, 4'hF, 1'b0); tick();
    applyStimulus(4'b0100, 4'hF, 1'b1); tick();
    checkOutput("t4 set wins", 32'(pending), 32'h4);
    checkOutput("t4 lost unchanged", 32'(lost_cnt), 32'd1);
    applyStimulus(4'b0000, 4'hF, 1'b1); tick(6);

    // Offer of 01 held while bit 3 rises; 11 follows after the accept.
    doReset();
    applyStimulus(4'b0010, 4'hF, 1'b0); tick();
    applyStimulus(4'b0000, 4'hF, 1'b0); tick();
    applyStimulus(4'b1000, 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      applyStimulus(4'b0000, 4'hF, 1'b0);
      checkOutput("t5 held code", 32'(svc_code), 32'd1);
      checkOutput("t5 held valid", 32'(svc_valid), 32'd1);
    end
    applyStimulus(4'b0000, 4'hF, 1'b1); tick();
    applyStimulus(4'b0000, 4'hF, 1'b0); tick(2);
    checkOutput("t5 next valid", 32'(svc_valid), 32'd1);
    checkOutput("t5 next code", 32'(svc_code), 32'd3);

    // Asynchronous reset mid-offer, bit 1 held high through release.
    rst = 1'b1;
    #1;
    checkOutput("t6 async valid", 32'(svc_valid), 32'd0);
    checkOutput("t6 async pending", 32'(pending), 32'h0);
    applyStimulus(4'b0010, 4'hF, 1'b0); tick(2);
    rst = 1'b0;
    tick();
    checkOutput("t6 held-high edge", 32'(pending), 32'h2);
    tick(4);
    checkOutput("t6 no lost", 32'(lost_cnt), 32'd0);
    checkOutput("t6 single pending", 32'(pending), 32'h2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      logic [3:0] m;
      r = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      applyStimulus(r, m, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
